alu_sequencer: RTL and testbench

Multi-cycle control FSM that fetches 16-bit instructions, decodes them into the 8-bit ALU opcode and operand controls, and sequences register-file writeback. Holds the processor status register (PSR) and feeds its carry bit back to the ALU. Sits between instruction memory, the register file and the ALU in the CPU datapath. Halts on bad opcodes and stalls on WAIT until woken.

---
 rtl/alu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle control FSM for a 16-bit CPU. Fetches instructions,
//            decodes them into ALU opcode / operand controls, sequences
//            register-file writeback, and owns the processor status register
//            (PSR) whose carry bit feeds back to the ALU. Stalls on the null
//            instruction (16'h0000) until woken; halts permanently on a
//            bad-opcode indication from the ALU (all flags set).
// Ports    :
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   inst_data    in  16   instruction word, valid with inst_valid
//   inst_valid   in   1   memory acknowledge for inst_req
//   inst_req     out  1   fetch request (address = pc)
//   pc           out 16   program counter
//   rf_raddr_a   out  4   operand A / destination = IR[11:8]
//   rf_raddr_b   out  4   operand B = IR[3:0]
//   rf_waddr     out  4   write address = IR[11:8]
//   rf_we        out  1   register-file write strobe (WRITEBACK only)
//   alu_opcode   out  8   {IR[15:12], IR[7:4]}
//   alu_carry_in out  1   psr[4]
//   imm_sel      out  1   ALU B takes imm_value
//   imm_value    out 16   extended immediate
//   alu_flags    in   5   {C, L, F, Z, N} from the ALU
//   psr          out  5   status register
//   wake         in   1   releases a STALL
//   halted       out  1   sticky bad-opcode indication
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] inst_data,
  input  logic        inst_valid,
  output logic        inst_req,
  output logic [15:0] pc,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  output logic [3:0]  rf_waddr,
  output logic        rf_we,
  output logic [7:0]  alu_opcode,
  output logic        alu_carry_in,
  output logic        imm_sel,
  output logic [15:0] imm_value,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  input  logic        wake,
  output logic        halted
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_STALL     = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  // Opcode fields that matter for writeback suppression
  localparam logic [3:0] c_EXT_CMP   = 4'b1011;
  localparam logic [3:0] c_EXT_CMPU  = 4'b1111;
  localparam logic [3:0] c_EXT_NOT   = 4'b0100;
  localparam logic [3:0] c_OP_CMPI   = 4'b1011;
  localparam logic [3:0] c_OP_CMPUI  = 4'b1111;
  localparam logic [3:0] c_OP_SHIFT  = 4'b1000;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [4:0]  r_psr;
  logic        r_halted;

  logic [3:0]  w_major;
  logic [3:0]  w_ext;
  logic        w_flag_op;
  logic        w_no_wb;
  logic        w_imm_sel;
  logic [15:0] w_imm_value;
  logic        w_inst_req;
  logic        w_rf_we;
  logic        w_bad_op;

  // The same code set marks flag-setting ops in both the register-form
  // extension field and the immediate-form major field.
  function automatic logic f_flag_code(input logic [3:0] code);
    case (code)
      4'b0101, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1111: f_flag_code = 1'b1;
      default:                                              f_flag_code = 1'b0;
    endcase
  endfunction

  assign w_major  = r_ir[15:12];
  assign w_ext    = r_ir[7:4];
  assign w_bad_op = (alu_flags == 5'b11111);

  // ---------------- Instruction decode (purely from IR) ----------------
  always_comb begin
    w_flag_op = (w_major == 4'b0000) ? f_flag_code(w_ext) : f_flag_code(w_major);

    w_no_wb = ((w_major == 4'b0000) &&
               ((w_ext == c_EXT_CMP) || (w_ext == c_EXT_CMPU) || (w_ext == c_EXT_NOT))) ||
              (w_major == c_OP_CMPI) || (w_major == c_OP_CMPUI);

    // Shift group: IR[6]=0 selects the immediate-count forms
    w_imm_sel = ((w_major != 4'b0000) && (w_major != c_OP_SHIFT)) ||
                ((w_major == c_OP_SHIFT) && !r_ir[6]);

    w_imm_value = 16'h0000;
    case (w_major)
      4'b0101, 4'b0111, 4'b1001, 4'b1010, 4'b1011:
        w_imm_value = {{8{r_ir[7]}}, r_ir[7:0]};
      4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1111:
        w_imm_value = {8'h00, r_ir[7:0]};
      4'b1000:
        w_imm_value = r_ir[6] ? 16'h0000 : {12'h000, r_ir[3:0]};
      default:
        w_imm_value = 16'h0000;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:     if (inst_valid) w_next_state = S_DECODE;
      S_DECODE:    w_next_state = (r_ir == 16'h0000) ? S_STALL : S_EXECUTE;
      S_EXECUTE:   w_next_state = w_bad_op ? S_HALT : S_WRITEBACK;
      S_WRITEBACK: w_next_state = S_FETCH;
      S_STALL:     if (wake) w_next_state = S_FETCH;
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Strobes are forced low while reset is held so nothing is issued
  // during the reset interval itself.
  always_comb begin
    w_inst_req = 1'b0;
    w_rf_we    = 1'b0;
    case (r_state)
      S_FETCH:     w_inst_req = !reset;
      S_WRITEBACK: w_rf_we    = !reset && !w_no_wb;
      default:     ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= 16'h0000;
      r_psr    <= 5'b00000;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:   if (inst_valid) r_ir <= inst_data;
        S_EXECUTE: begin
          if (w_bad_op)       r_halted <= 1'b1;
          else if (w_flag_op) r_psr    <= alu_flags;
        end
        S_WRITEBACK: r_pc <= r_pc + 16'd1;
        S_STALL:     if (wake) r_pc <= r_pc + 16'd1;
        default:     ;
      endcase
    end
  end

  assign inst_req     = w_inst_req;
  assign pc           = r_pc;
  assign rf_raddr_a   = r_ir[11:8];
  assign rf_raddr_b   = r_ir[3:0];
  assign rf_waddr     = r_ir[11:8];
  assign rf_we        = w_rf_we;
  assign alu_opcode   = {w_major, w_ext};
  assign alu_carry_in = r_psr[4];
  assign imm_sel      = w_imm_sel;
  assign imm_value    = w_imm_value;
  assign psr          = r_psr;
  assign halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer. RESET_PC is set
//            near the top of the address space so the pc wrap is exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam logic [15:0] c_RESET_PC = 16'hFFFE;

  logic        clk;
  logic        reset;
  logic [15:0] inst_data;
  logic        inst_valid;
  logic        inst_req;
  logic [15:0] pc;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [3:0]  rf_waddr;
  logic        rf_we;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic        imm_sel;
  logic [15:0] imm_value;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        wake;
  logic        halted;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.RESET_PC(c_RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_data    (inst_data),
    .inst_valid   (inst_valid),
    .inst_req     (inst_req),
    .pc           (pc),
    .rf_raddr_a   (rf_raddr_a),
    .rf_raddr_b   (rf_raddr_b),
    .rf_waddr     (rf_waddr),
    .rf_we        (rf_we),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .imm_sel      (imm_sel),
    .imm_value    (imm_value),
    .alu_flags    (alu_flags),
    .psr          (psr),
    .wake         (wake),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in FETCH with same-cycle acknowledge; returns in DECODE.
  task automatic do_fetch(input logic [15:0] d, input logic [4:0] f);
    inst_valid = 1'b1;
    inst_data  = d;
    alu_flags  = f;
    tick();
    inst_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inst_valid = 1'b0; inst_data = 16'h0000;
    alu_flags = 5'b00000; wake = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",       pc,         c_RESET_PC);
    chk("rst_psr",      psr,        16'h0000);
    chk("rst_halted",   halted,     16'h0000);
    chk("rst_rf_we",    rf_we,      16'h0000);
    chk("rst_inst_req", inst_req,   16'h0000);
    chk("rst_imm_sel",  imm_sel,    16'h0000);
    chk("rst_opcode",   alu_opcode, 16'h0000);
    reset = 1'b0;
    #1;
    chk("fetch_req", inst_req, 16'h0001);

    // ADD R1,R2
    do_fetch(16'h0152, 5'b00010);
    chk("add_opcode",  alu_opcode, 16'h0005);
    chk("add_ra",      rf_raddr_a, 16'h0001);
    chk("add_rb",      rf_raddr_b, 16'h0002);
    chk("add_immsel",  imm_sel,    16'h0000);
    chk("add_dec_req", inst_req,   16'h0000);
    tick();
    chk("add_ex_we",   rf_we,      16'h0000);
    chk("add_ex_psr",  psr,        16'h0000);
    tick();
    chk("add_wb_psr",  psr,        16'h0002);
    chk("add_wb_we",   rf_we,      16'h0001);
    chk("add_wb_wa",   rf_waddr,   16'h0001);
    chk("add_wb_pc",   pc,         16'hFFFE);
    tick();
    chk("add_f_we",    rf_we,      16'h0000);
    chk("add_f_pc",    pc,         16'hFFFF);
    chk("add_f_req",   inst_req,   16'h0001);

    // ADDI R3,#-1
    do_fetch(16'h53FF, 5'b00100);
    chk("addi_opcode", alu_opcode, 16'h005F);
    chk("addi_immsel", imm_sel,    16'h0001);
    chk("addi_imm",    imm_value,  16'hFFFF);
    tick(); tick();
    chk("addi_wb_we",  rf_we,      16'h0001);
    tick();
    chk("addi_pc_wrap", pc,        16'h0000);
    chk("addi_psr",    psr,        16'h0004);

    // ANDI R3,#F0 (not flag-setting)
    do_fetch(16'h13F0, 5'b00000);
    chk("andi_opcode", alu_opcode, 16'h001F);
    chk("andi_immsel", imm_sel,    16'h0001);
    chk("andi_imm",    imm_value,  16'h00F0);
    tick(); tick(); tick();
    chk("andi_psr",    psr,        16'h0004);
    chk("andi_pc",     pc,         16'h0001);

    // CMP R1,R2: flags written, no writeback
    do_fetch(16'h01B2, 5'b01000);
    chk("cmp_opcode",  alu_opcode, 16'h000B);
    tick(); tick();
    chk("cmp_wb_we",   rf_we,      16'h0000);
    chk("cmp_psr",     psr,        16'h0008);
    tick();
    chk("cmp_carry",   alu_carry_in, 16'h0000);
    chk("cmp_pc",      pc,         16'h0002);

    // SUB sets C so the following ADDC sees carry_in=1
    do_fetch(16'h0192, 5'b10001);
    tick(); tick(); tick();
    chk("sub_psr",     psr,          16'h0011);
    chk("sub_carry",   alu_carry_in, 16'h0001);

    // ADDC R1,R2
    do_fetch(16'h0172, 5'b00011);
    chk("addc_opcode", alu_opcode,   16'h0007);
    chk("addc_cin",    alu_carry_in, 16'h0001);
    tick(); tick(); tick();
    chk("addc_psr",    psr,          16'h0003);
    chk("addc_cin2",   alu_carry_in, 16'h0000);

    // ADDU leaves psr alone even with flags asserted
    do_fetch(16'h0162, 5'b11110);
    tick(); tick(); tick();
    chk("addu_psr",    psr,        16'h0003);
    chk("addu_pc",     pc,         16'h0005);

    // LSHI R1,#3 and register shift LSH R1,R2
    do_fetch(16'h8103, 5'b00000);
    chk("lshi_opcode", alu_opcode, 16'h0080);
    chk("lshi_immsel", imm_sel,    16'h0001);
    chk("lshi_imm",    imm_value,  16'h0003);
    tick(); tick(); tick();
    do_fetch(16'h8142, 5'b00000);
    chk("lsh_immsel",  imm_sel,    16'h0000);
    chk("lsh_imm",     imm_value,  16'h0000);
    tick(); tick(); tick();

    // FETCH held while memory is slow; wake outside STALL ignored
    wake = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", inst_req, 16'h0001);
      chk("wait_pc",  pc,       16'h0007);
      tick();
      wake = 1'b0;
    end

    // Null instruction -> STALL; stray inst_valid ignored
    do_fetch(16'h0000, 5'b00000);
    tick();
    inst_valid = 1'b1;
    inst_data  = 16'h0152;
    for (int i = 0; i < 10; i++) begin
      chk("stall_pc",  pc,       16'h0007);
      chk("stall_req", inst_req, 16'h0000);
      tick();
    end
    inst_valid = 1'b0;
    wake = 1'b1;
    tick();
    wake = 1'b0;
    chk("wake_pc",  pc,       16'h0008);
    chk("wake_req", inst_req, 16'h0001);

    // Bad opcode -> HALT
    do_fetch(16'hC000, 5'b11111);
    tick();
    chk("halt_ex",     halted,   16'h0000);
    tick();
    chk("halt_set",    halted,   16'h0001);
    chk("halt_we",     rf_we,    16'h0000);
    chk("halt_req",    inst_req, 16'h0000);
    chk("halt_pc",     pc,       16'h0008);
    chk("halt_psr",    psr,      16'h0003);
    inst_valid = 1'b1;
    repeat (4) tick();
    chk("halt_sticky", halted,   16'h0001);
    chk("halt_pc2",    pc,       16'h0008);
    chk("halt_req2",   inst_req, 16'h0000);
    inst_valid = 1'b0;
    alu_flags  = 5'b00000;

    // Asynchronous reset clears HALT between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_halted", halted, 16'h0000);
    chk("arst_pc",     pc,     c_RESET_PC);
    chk("arst_psr",    psr,    16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-EXECUTE
    do_fetch(16'h53FF, 5'b00110);
    tick(); tick(); tick();
    chk("pre_psr", psr, 16'h0006);
    chk("pre_pc",  pc,  16'hFFFF);
    do_fetch(16'h0152, 5'b10101);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_pc",  pc,       c_RESET_PC);
    chk("mid_psr", psr,      16'h0000);
    chk("mid_we",  rf_we,    16'h0000);
    chk("mid_req", inst_req, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_req",    inst_req,   16'h0001);
    chk("post_opcode", alu_opcode, 16'h0000);
    chk("post_psr",    psr,        16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
